// File: rtl/vga_fb_sram_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_sram_if
//  Purpose  : AXI4 bus bundle between the framebuffer slave and its masters
//             (CPU pixel writer on AW/W/B, VGA line fetcher on AR/R).
//  Ports    : aw*/w*/b* write address, data and response channels
//             ar*/r*    read address and data channels
//             modport master drives requests, modport slave drives responses
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_fb_sram_if #(
  parameter int ID_W = 4
);
  logic            awready;
  logic            awvalid;
  logic [31:0]     awaddr;
  logic [ID_W-1:0] awid;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            wready;
  logic            wvalid;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wlast;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;
  logic            arready;
  logic            arvalid;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            rvalid;
  logic            rready;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic [ID_W-1:0] rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface
`default_nettype wire

// File: rtl/vga_fb_sram.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_sram
//  Purpose  : AXI4 slave framebuffer on one single-port SRAM (64-bit words,
//             1-cycle read). Reads drain through a 2-entry output buffer so
//             rready back-pressure never drops a beat.
//  Ports    : clock    - rising-edge clock
//             resetn   - asynchronous active-low reset
//             io_slave - AXI4 slave (vga_fb_sram_if.slave)
//  Options  : VGA_FB_RD_PRIORITY_EN - when defined, a read issue always wins
//             an SRAM conflict; otherwise conflicts alternate.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_fb_sram #(
  parameter int DEPTH_LOG2 = 16,
  parameter int ID_W       = 4
) (
  input wire logic     clock,
  input wire logic     resetn,
  vga_fb_sram_if.slave io_slave
);
  localparam int c_depth = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_t;

  logic [63:0] r_mem [c_depth];

  w_state_t              r_w_state, w_w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_wr_addr;
  logic [ID_W-1:0]       r_wr_id;
  logic                  r_wr_fixed;

  r_state_t              r_r_state, w_r_state_nxt;
  logic [DEPTH_LOG2-1:0] r_rd_addr;
  logic [ID_W-1:0]       r_rd_id;
  logic                  r_rd_fixed;
  logic [8:0]            r_rd_remain;   // beats still to issue

  logic [63:0]           r_buf_data [2];
  logic [1:0]            r_buf_last;
  logic                  r_buf_wptr, r_buf_rptr;
  logic [1:0]            r_buf_count;

  logic w_rd_want, w_wr_want, w_rd_wins, w_rd_grant, w_wr_grant, w_pop, w_rvalid;
  logic w_unused;

  // Fields accepted on the bus but deliberately ignored (size forced to 8 B,
  // length taken from wlast, address bits outside the word index).
  assign w_unused = ^{io_slave.awlen, io_slave.awsize, io_slave.arsize,
                      io_slave.awaddr, io_slave.araddr};

  // ---------------------------------------------------------------- arbitration
  // Reads only ask when the buffer has room; data lands in the buffer at the
  // end of the issue cycle, so occupancy alone bounds outstanding beats.
  assign w_rd_want = (r_r_state == R_BURST) && (r_rd_remain != 9'd0) && (r_buf_count != 2'd2);
  assign w_wr_want = (r_w_state == W_DATA) && io_slave.wvalid;

`ifdef VGA_FB_RD_PRIORITY_EN
  assign w_rd_wins = 1'b1;
`else
  logic r_last_rd_won;   // winner of the most recent conflict

  assign w_rd_wins = !r_last_rd_won;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_last_rd_won <= 1'b0;
    else if (w_rd_want && w_wr_want)
      r_last_rd_won <= w_rd_grant;
  end
`endif

  assign w_rd_grant = w_rd_want && (!w_wr_want || w_rd_wins);
  assign w_wr_grant = w_wr_want && !w_rd_grant;

  // ---------------------------------------------------------------- outputs
  assign w_rvalid         = (r_buf_count != 2'd0);
  assign w_pop            = w_rvalid && io_slave.rready;

  assign io_slave.awready = (r_w_state == W_IDLE);
  assign io_slave.wready  = (r_w_state == W_DATA) && !w_rd_grant;
  assign io_slave.bvalid  = (r_w_state == W_RESP);
  assign io_slave.bresp   = 2'b00;
  assign io_slave.bid     = r_wr_id;
  assign io_slave.arready = (r_r_state == R_IDLE);
  assign io_slave.rvalid  = w_rvalid;
  assign io_slave.rdata   = r_buf_data[r_buf_rptr];
  assign io_slave.rlast   = w_rvalid && r_buf_last[r_buf_rptr];
  assign io_slave.rresp   = 2'b00;
  assign io_slave.rid     = r_rd_id;

  // ---------------------------------------------------------------- write FSM
  always_comb begin
    w_w_state_nxt = r_w_state;
    unique case (r_w_state)
      W_IDLE:  if (io_slave.awvalid)                w_w_state_nxt = W_DATA;
      W_DATA:  if (w_wr_grant && io_slave.wlast)    w_w_state_nxt = W_RESP;
      W_RESP:  if (io_slave.bready)                 w_w_state_nxt = W_IDLE;
      default:                                      w_w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_w_state  <= W_IDLE;
      r_wr_addr  <= '0;
      r_wr_id    <= '0;
      r_wr_fixed <= 1'b0;
    end else begin
      r_w_state <= w_w_state_nxt;
      if (r_w_state == W_IDLE && io_slave.awvalid) begin
        r_wr_addr  <= io_slave.awaddr[DEPTH_LOG2+2:3];
        r_wr_id    <= io_slave.awid;
        r_wr_fixed <= (io_slave.awburst == 2'b00);
      end else if (w_wr_grant && !r_wr_fixed) begin
        r_wr_addr  <= r_wr_addr + 1'b1;   // wraps at the top of the SRAM
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_grant) begin
      for (int b = 0; b < 8; b++) begin
        if (io_slave.wstrb[b])
          r_mem[r_wr_addr][8*b +: 8] <= io_slave.wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read FSM
  always_comb begin
    w_r_state_nxt = r_r_state;
    unique case (r_r_state)
      R_IDLE:  if (io_slave.arvalid)                 w_r_state_nxt = R_BURST;
      R_BURST: if (w_pop && r_buf_last[r_buf_rptr])  w_r_state_nxt = R_IDLE;
      default:                                       w_r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_r_state   <= R_IDLE;
      r_rd_addr   <= '0;
      r_rd_id     <= '0;
      r_rd_fixed  <= 1'b0;
      r_rd_remain <= '0;
    end else begin
      r_r_state <= w_r_state_nxt;
      if (r_r_state == R_IDLE && io_slave.arvalid) begin
        r_rd_addr   <= io_slave.araddr[DEPTH_LOG2+2:3];
        r_rd_id     <= io_slave.arid;
        r_rd_fixed  <= (io_slave.arburst == 2'b00);
        r_rd_remain <= {1'b0, io_slave.arlen} + 9'd1;
      end else if (w_rd_grant) begin
        r_rd_remain <= r_rd_remain - 9'd1;
        if (!r_rd_fixed)
          r_rd_addr <= r_rd_addr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- output buffer
  // The SRAM read port writes straight into the buffer tail, which gives the
  // 1-cycle read latency and keeps rdata stable while the head is stalled.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last    <= '0;
      r_buf_wptr    <= 1'b0;
      r_buf_rptr    <= 1'b0;
      r_buf_count   <= '0;
    end else begin
      if (w_rd_grant) begin
        r_buf_data[r_buf_wptr] <= r_mem[r_rd_addr];
        r_buf_last[r_buf_wptr] <= (r_rd_remain == 9'd1);
        r_buf_wptr             <= ~r_buf_wptr;
      end
      if (w_pop)
        r_buf_rptr <= ~r_buf_rptr;
      r_buf_count <= r_buf_count + {1'b0, w_rd_grant} - {1'b0, w_pop};
    end
  end
endmodule
`default_nettype wire
